// File: rtl/phase_timing_generator.sv
// Two-phase machine clock generator with edge strobes and T-state sequencer.
// Latency: all outputs registered, decoded from the next phase-counter value.
// Backpressure: RDY low at the phase_2 start stalls the following machine cycle.
//
// Ports:
//   sys_clock, reset    - clock and synchronous active-high reset
//   ready, last_cycle   - RDY and end-of-instruction from decode, sampled at phase_2 start
//   phase_1, phase_2    - non-overlapping phase windows
//   phase_1_rising, phase_2_rising, phase_2_falling - one-cycle edge strobes
//   t_state, sync       - instruction timing state and opcode-fetch flag
//   stall, seq_error    - stalled machine cycle flag and sticky T-state overrun flag
module phase_timing_generator #(
  parameter int PHASE_LEN = 4,
  parameter int DEAD_TIME = 1,
  parameter int MAX_T     = 6
) (
  input  logic       sys_clock,
  input  logic       reset,
  input  logic       ready,
  input  logic       last_cycle,
  output logic       phase_1,
  output logic       phase_2,
  output logic       phase_1_rising,
  output logic       phase_2_rising,
  output logic       phase_2_falling,
  output logic [2:0] t_state,
  output logic       sync,
  output logic       stall,
  output logic       seq_error
);

  localparam int P  = 2 * PHASE_LEN;
  localparam int CW = $clog2(P);

  localparam logic [CW-1:0] CNT_LAST = CW'(P - 1);
  localparam logic [CW-1:0] P1_START = CW'(DEAD_TIME);
  localparam logic [CW-1:0] P1_END   = CW'(PHASE_LEN - 1);
  localparam logic [CW-1:0] P2_START = CW'(PHASE_LEN + DEAD_TIME);
  localparam logic [2:0]    T_MAX    = 3'(MAX_T);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          started;
  logic          started_nxt;
  logic          wrap;
  logic          rdy_q;
  logic          last_q;

  always_comb begin
    wrap        = (cnt == CNT_LAST);
    cnt_nxt     = wrap ? '0 : cnt + CW'(1);
    started_nxt = started | wrap;
  end

  // Phase counter and phase decode. Decoding from cnt_nxt lets the
  // registered outputs line up with the counter value they describe.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      cnt             <= '0;
      started         <= 1'b0;
      phase_1         <= 1'b0;
      phase_2         <= 1'b0;
      phase_1_rising  <= 1'b0;
      phase_2_rising  <= 1'b0;
      phase_2_falling <= 1'b0;
    end else begin
      cnt             <= cnt_nxt;
      started         <= started_nxt;
      phase_1         <= (cnt_nxt >= P1_START) && (cnt_nxt <= P1_END);
      // Upper bound P-1 is implied by the counter range.
      phase_2         <= (cnt_nxt >= P2_START);
      phase_1_rising  <= (cnt_nxt == P1_START);
      phase_2_rising  <= (cnt_nxt == P2_START);
      phase_2_falling <= (cnt_nxt == '0) && started_nxt;
    end
  end

  // T-state sequencer. Inputs are sampled on the phase_2 start edge and
  // acted upon at the end of the machine cycle, so mid-cycle glitches on
  // ready/last_cycle have no effect.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      rdy_q     <= 1'b1;
      last_q    <= 1'b0;
      t_state   <= '0;
      sync      <= 1'b1;
      stall     <= 1'b0;
      seq_error <= 1'b0;
    end else begin
      if (cnt_nxt == P2_START) begin
        rdy_q  <= ready;
        last_q <= last_cycle;
      end
      if (wrap) begin
        if (!rdy_q) begin
          // Stall wins over last_cycle; decode must re-assert it next cycle.
          stall <= 1'b1;
        end else if (last_q) begin
          t_state <= '0;
          sync    <= 1'b1;
          stall   <= 1'b0;
        end else if (t_state == T_MAX) begin
          seq_error <= 1'b1;
          stall     <= 1'b0;
        end else begin
          // t_state < MAX_T <= 7 here, so the increment never lands on 0.
          t_state <= t_state + 3'd1;
          sync    <= 1'b0;
          stall   <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_phase_timing_generator.sv
module tb_phase_timing_generator;

  logic sys_clock = 1'b0;
  logic reset     = 1'b1;
  logic ready     = 1'b1;
  logic last_cycle = 1'b0;

  logic [1:0] p1, p2, r1, r2, f2, sy, st, er;
  logic [2:0] ts0, ts1;

  int total = 0;
  int bad   = 0;

  always #5 sys_clock = ~sys_clock;

  phase_timing_generator dut0 (
    .sys_clock(sys_clock), .reset(reset), .ready(ready), .last_cycle(last_cycle),
    .phase_1(p1[0]), .phase_2(p2[0]), .phase_1_rising(r1[0]), .phase_2_rising(r2[0]),
    .phase_2_falling(f2[0]), .t_state(ts0), .sync(sy[0]), .stall(st[0]), .seq_error(er[0])
  );

  phase_timing_generator #(.PHASE_LEN(2), .DEAD_TIME(1), .MAX_T(6)) dut1 (
    .sys_clock(sys_clock), .reset(reset), .ready(ready), .last_cycle(last_cycle),
    .phase_1(p1[1]), .phase_2(p2[1]), .phase_1_rising(r1[1]), .phase_2_rising(r2[1]),
    .phase_2_falling(f2[1]), .t_state(ts1), .sync(sy[1]), .stall(st[1]), .seq_error(er[1])
  );

  // Behavioural model: edge count since reset, T-state as an integer.
  int mp[2]  = '{8, 4};
  int mpl[2] = '{4, 2};
  int mdt[2] = '{1, 1};
  int mk[2];
  int mts[2];
  bit mst[2], mer[2], mrdy[2], mlast[2];
  bit chk_en = 1'b0;

  always @(posedge sys_clock) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        mk[i] = 0; mts[i] = 0; mst[i] = 0; mer[i] = 0; mrdy[i] = 1; mlast[i] = 0;
      end else begin
        int c;
        mk[i] = mk[i] + 1;
        c = mk[i] % mp[i];
        if (c == mpl[i] + mdt[i]) begin
          mrdy[i]  = ready;
          mlast[i] = last_cycle;
        end
        if (c == 0) begin
          if (!mrdy[i])        mst[i] = 1;
          else if (mlast[i]) begin mts[i] = 0; mst[i] = 0; end
          else if (mts[i] == 6) begin mer[i] = 1; mst[i] = 0; end
          else begin mts[i] = mts[i] + 1; mst[i] = 0; end
        end
      end
    end
    if (reset) chk_en = 1'b1;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge sys_clock) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int c;
        int ts_act;
        c = mk[i] % mp[i];
        ts_act = (i == 0) ? int'(ts0) : int'(ts1);
        check($sformatf("dut%0d.phase_1", i), p1[i], (c >= mdt[i] && c <= mpl[i] - 1) ? 1 : 0);
        check($sformatf("dut%0d.phase_2", i), p2[i], (c >= mpl[i] + mdt[i]) ? 1 : 0);
        check($sformatf("dut%0d.phase_1_rising", i), r1[i], (c == mdt[i]) ? 1 : 0);
        check($sformatf("dut%0d.phase_2_rising", i), r2[i], (c == mpl[i] + mdt[i]) ? 1 : 0);
        check($sformatf("dut%0d.phase_2_falling", i), f2[i], (c == 0 && mk[i] > 0) ? 1 : 0);
        check($sformatf("dut%0d.t_state", i), ts_act, mts[i]);
        check($sformatf("dut%0d.sync", i), sy[i], (mts[i] == 0) ? 1 : 0);
        check($sformatf("dut%0d.stall", i), st[i], mst[i]);
        check($sformatf("dut%0d.seq_error", i), er[i], mer[i]);
        check($sformatf("dut%0d.no_overlap", i), p1[i] & p2[i], 0);
      end
    end
  end

  task automatic wait_k(input int t);
    int n = 0;
    while (mk[0] != t) begin
      @(negedge sys_clock);
      n++;
      if (n > 2000) begin
        check($sformatf("wait_k_%0d_timeout", t), 0, 1);
        break;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge sys_clock);
    reset = 1'b0;

    // Reset release timing, literal expectations.
    wait_k(1);
    check("e1.phase_1_rising", r1[0], 1);
    check("e1.phase_1", p1[0], 1);
    check("e1.p4.phase_1", p1[1], 1);
    wait_k(3);
    check("e3.p4.phase_2_rising", r2[1], 1);
    check("e3.phase_1", p1[0], 1);
    wait_k(4);
    check("e4.dead", p1[0] | p2[0], 0);
    check("e4.p4.phase_2_falling", f2[1], 1);
    wait_k(5);
    check("e5.phase_2_rising", r2[0], 1);
    wait_k(8);
    check("e8.phase_2_falling", f2[0], 1);
    check("e8.t_state", ts0, 1);
    check("e8.sync", sy[0], 0);
    wait_k(9);
    check("e9.phase_1_rising", r1[0], 1);

    // last_cycle during the third machine cycle.
    wait_k(16);
    check("e16.t_state", ts0, 2);
    last_cycle = 1'b1;
    wait_k(23);
    last_cycle = 1'b0;
    wait_k(24);
    check("e24.t_state", ts0, 0);
    check("e24.sync", sy[0], 1);

    // RDY low at the phase_2 start of T1.
    wait_k(32);
    check("e32.t_state", ts0, 1);
    ready = 1'b0;
    wait_k(39);
    ready = 1'b1;
    wait_k(40);
    check("e40.t_state", ts0, 1);
    check("e40.stall", st[0], 1);
    wait_k(48);
    check("e48.t_state", ts0, 2);
    check("e48.stall", st[0], 0);

    // RDY low only between strobes: no stall.
    ready = 1'b0;
    wait_k(52);
    ready = 1'b1;
    wait_k(56);
    check("e56.t_state", ts0, 3);
    check("e56.stall", st[0], 0);

    // T-state overrun.
    wait_k(80);
    check("e80.t_state", ts0, 6);
    check("e80.seq_error", er[0], 0);
    wait_k(88);
    check("e88.t_state", ts0, 6);
    check("e88.seq_error", er[0], 1);
    wait_k(96);
    check("e96.seq_error", er[0], 1);
    last_cycle = 1'b1;
    wait_k(103);
    last_cycle = 1'b0;
    wait_k(104);
    check("e104.t_state", ts0, 0);
    check("e104.seq_error", er[0], 1);

    // Reset during phase_2 of T3.
    wait_k(128);
    check("e128.t_state", ts0, 3);
    wait_k(133);
    reset = 1'b1;
    @(negedge sys_clock);
    check("rst.t_state", ts0, 0);
    check("rst.sync", sy[0], 1);
    check("rst.seq_error", er[0], 0);
    check("rst.phase_2", p2[0], 0);
    reset = 1'b0;
    wait_k(1);
    check("re1.phase_1_rising", r1[0], 1);
    wait_k(8);
    check("re8.phase_2_falling", f2[0], 1);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      @(negedge sys_clock);
      ready      = ($urandom_range(0, 3) != 0);
      last_cycle = ($urandom_range(0, 3) == 0);
      reset      = ($urandom_range(0, 399) == 0);
    end
    reset = 1'b0;
    repeat (2) @(negedge sys_clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phase_timing_generator.md
Name: phase_timing_generator

Overview:
- Generates the two-phase machine clocking (phase_1/phase_2 windows with dead time) from sys_clock.
- Provides the single-cycle edge strobes, including phase_2_rising, that the program counter and the other datapath registers use as load enables.
- Tracks the instruction timing state (T-state), SYNC (opcode-fetch cycle) and RDY stalls.
- Sits directly upstream of the program counter and the bus control decode.

Parameters:
PHASE_LEN, 4, sys_clock cycles per half machine cycle; machine cycle P = 2*PHASE_LEN; legal range ≥2.
DEAD_TIME, 1, sys_clock cycles of non-overlap at the start of each half; legal range 0 < DEAD_TIME < PHASE_LEN.
MAX_T, 6, highest legal T-state index.

Ports:
sys_clock  input  1  system clock
reset  input  1  synchronous, active-high reset
ready  input  1  RDY; low requests a stall of the next machine cycle
last_cycle  input  1  from decode: current machine cycle is the final cycle of the instruction
phase_1  output  1  phase 1 window
phase_2  output  1  phase 2 window
phase_1_rising  output  1  one-sys_clock strobe at start of phase_1
phase_2_rising  output  1  one-sys_clock strobe at start of phase_2
phase_2_falling  output  1  one-sys_clock strobe at end of machine cycle
t_state  output  3  current T-state, 0..MAX_T
sync  output  1  high while t_state==0 (opcode fetch)
stall  output  1  current machine cycle is a RDY stall
seq_error  output  1  sticky; T-state overran MAX_T

Behaviour:
- Clock and reset: one clock, sys_clock. Reset is synchronous and active-high. All state and outputs are registers updated only on posedge sys_clock.
- Reset values: cnt=0, started=0, all outputs 0, except sync=1 because t_state=0.
- Reset mid-operation returns everything to these values at that edge. Any partial machine cycle is discarded.

Phase counter cnt (0..P-1):
- Each non-reset edge: cnt <= (cnt==P-1) ? 0 : cnt+1.
- Outputs are registered, decoded from the next value of cnt, so they align with cnt:
  - phase_1 = DEAD_TIME ≤ cnt ≤ PHASE_LEN-1
  - phase_2 = PHASE_LEN+DEAD_TIME ≤ cnt ≤ P-1
  - phase_1_rising = (cnt==DEAD_TIME)
  - phase_2_rising = (cnt==PHASE_LEN+DEAD_TIME)
  - phase_2_falling = (cnt==0 && started)
- started is set on the first wrap from P-1 to 0.
- phase_1 and phase_2 are never high together. Each strobe is exactly one sys_clock wide, once per machine cycle.
- Defaults (P=8, DEAD=1), first edges after reset release give cnt = 1,2,…,7,0,1,…:
  - phase_1 high for 3 cycles.
  - 1 dead cycle.
  - phase_2 high for 3 cycles.
  - phase_2_falling on the 8th edge.
  - phase_1_rising on edges 1, 9, 17, …

Sampling:
- ready and last_cycle are captured into rdy_q and last_q on the edge that asserts phase_2_rising.
- They are ignored at all other times.

T-state update:
- Updated only on the edge where cnt wraps to 0, i.e. same edge as phase_2_falling. Priority order:
  1. rdy_q==0: t_state held; stall<=1 for the coming machine cycle.
  2. last_q==1: t_state<=0; stall<=0.
  3. t_state==MAX_T: t_state held; seq_error<=1; stall<=0.
  4. Otherwise t_state<=t_state+1; stall<=0.
- A stall holds t_state even if last_cycle was also high. last_cycle must be re-asserted in the following cycle.
- seq_error clears only on reset.
- sync is registered together with t_state, equal to (t_state==0). During a stalled T0, sync stays high.

Test Plan:
- Reset held 3 cycles, then released, defaults: phase_1 high on edges 1–3, low on 4, phase_2 high on 5–7, phase_2_falling pulse on edge 8, phase_1_rising on 9; phases never overlap.
- ready=1, last_cycle asserted during the 3rd machine cycle → t_state sequence 0,1,2,0; sync high during cycles 1 and 4 only.
- ready=0 at the phase_2_rising of T1 → next machine cycle stall=1, t_state stays 1; ready=1 again → t_state advances to 2, stall=0.
- ready toggled low/high between phase_2_rising strobes (not at the strobe) → no stall, sequence unaffected.
- last_cycle never asserted → t_state reaches 6, holds at 6; seq_error=1 at the wrap after T6 and stays set until reset.
- reset asserted during phase_2 of T3 → next edge: all outputs 0, sync=1, t_state=0, seq_error cleared; timing restarts exactly as in scenario 1.
- PHASE_LEN=2, DEAD_TIME=1 → P=4; phase_1 is high only at cnt=1, phase_2 only at cnt=3; each strobe fires once per 4 sys_clock cycles.
